// File: rtl/csi2_pkg.sv
// rtl/csi2_pkg.sv - shared header type, FSM states and constants for the CSI-2 packet controller
package csi2_pkg;

  typedef struct packed {
    logic [7:0]  data_id;
    logic [15:0] word_count;
    logic [7:0]  ecc;
  } csi2_hdr_t;

  localparam logic [5:0] SHORT_PKT_DT_MAX = 6'h0F;
  localparam int         CRC_BYTES        = 2;

  typedef enum logic [2:0] {IDLE, SYNC, HEADER, PAYLOAD, DONE} ctrl_state_t;

endpackage

// File: rtl/csi2_hdr_collect.sv
// rtl/csi2_hdr_collect.sv - assembles the 4-byte packet header from aligned lane words
module csi2_hdr_collect
  import csi2_pkg::*;
#(
  parameter int DATA_LANES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    clear_i,
  input  logic                    beat_i,
  input  logic [DATA_LANES*8-1:0] word_i,
  output csi2_hdr_t               hdr_o,
  output logic                    done_o
);

  localparam int BEATS = (DATA_LANES >= 4) ? 1 : 4 / DATA_LANES;

  logic [1:0]  r_idx;
  logic [31:0] r_bytes;
  logic [31:0] w_bytes;

  // Merge the current beat into the bytes already held so the header is complete on its last beat.
  always_comb begin
    w_bytes = r_bytes;
    for (int i = 0; i < DATA_LANES; i++) begin
      w_bytes[(int'(r_idx) * DATA_LANES + i) * 8 +: 8] = word_i[i*8 +: 8];
    end
  end

  assign done_o = beat_i && (r_idx == 2'(BEATS - 1));
  assign hdr_o  = '{data_id: w_bytes[7:0], word_count: w_bytes[23:8], ecc: w_bytes[31:24]};

  // Beat index and partial header bytes; cleared whenever the controller is between packets.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clear_i) begin
      r_idx   <= '0;
      r_bytes <= '0;
    end else if (beat_i) begin
      r_bytes <= w_bytes;
      r_idx   <= done_o ? 2'd0 : r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/csi2_pkt_ctrl.sv
// rtl/csi2_pkt_ctrl.sv - packet sequencer: arms the aligner, parses headers, counts payload and CRC
module csi2_pkt_ctrl
  import csi2_pkg::*;
#(
  parameter int DATA_LANES = 4
) (
  input  logic                    byte_clk_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic [DATA_LANES*8-1:0] word_i,
  input  logic                    valid_i,
  output logic                    wait_for_sync_o,
  output logic                    pkt_done_o,
  output logic                    hdr_valid_o,
  output logic [7:0]              data_id_o,
  output logic [15:0]             word_count_o,
  output logic [7:0]              ecc_o,
  output logic [DATA_LANES*8-1:0] pld_data_o,
  output logic                    pld_valid_o,
  output logic [DATA_LANES-1:0]   pld_strb_o,
  output logic                    pld_last_o,
  output logic                    trunc_err_o
);

  if (DATA_LANES != 1 && DATA_LANES != 2 && DATA_LANES != 4) begin : g_lanes_check
    $error("csi2_pkt_ctrl: DATA_LANES must be 1, 2 or 4");
  end

  ctrl_state_t             r_state, w_next;
  logic                    r_wait, r_done, r_hdr_valid, r_pld_valid, r_pld_last, r_trunc;
  logic [7:0]              r_data_id, r_ecc;
  logic [15:0]             r_word_count;
  logic [DATA_LANES*8-1:0] r_pld_data;
  logic [DATA_LANES-1:0]   r_pld_strb, w_strb;
  logic [16:0]             r_rem;
  logic                    w_hdr_beat, w_pld_beat, w_trunc, w_last, w_short, w_hdr_done, w_clear;
  csi2_hdr_t               w_hdr;

  assign w_clear = !enable_i || (r_state == IDLE) || (r_state == DONE);
  assign w_short = (w_hdr.data_id[5:0] <= SHORT_PKT_DT_MAX);
  assign w_last  = (r_rem <= 17'(DATA_LANES));

  csi2_hdr_collect #(.DATA_LANES(DATA_LANES)) u_hdr_collect (
    .clk_i   (byte_clk_i),
    .rst_n_i (rst_n_i),
    .clear_i (w_clear),
    .beat_i  (w_hdr_beat),
    .word_i  (word_i),
    .hdr_o   (w_hdr),
    .done_o  (w_hdr_done)
  );

  // Byte strobes for this payload beat: the lowest min(rem, DATA_LANES) lanes.
  always_comb begin
    w_strb = '0;
    for (int i = 0; i < DATA_LANES; i++) begin
      w_strb[i] = (r_rem > 17'(i));
    end
  end

  // Next-state decode; a beat in SYNC is only taken once the aligner has actually been armed.
  always_comb begin
    w_next     = r_state;
    w_hdr_beat = 1'b0;
    w_pld_beat = 1'b0;
    w_trunc    = 1'b0;
    if (!enable_i) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: w_next = SYNC;
        SYNC: begin
          if (valid_i && r_wait) begin
            w_hdr_beat = 1'b1;
            w_next     = w_hdr_done ? (w_short ? DONE : PAYLOAD) : HEADER;
          end
        end
        HEADER: begin
          if (!valid_i) begin
            w_trunc = 1'b1;
            w_next  = DONE;
          end else begin
            w_hdr_beat = 1'b1;
            if (w_hdr_done) w_next = w_short ? DONE : PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!valid_i) begin
            w_trunc = 1'b1;
            w_next  = DONE;
          end else begin
            w_pld_beat = 1'b1;
            if (w_last) w_next = DONE;
          end
        end
        DONE:    w_next = SYNC;
        default: w_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge byte_clk_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Registered outputs and remaining-byte counter; the re-arm waits one cycle after the done pulse.
  always_ff @(posedge byte_clk_i) begin
    if (!rst_n_i) begin
      r_wait       <= 1'b0;
      r_done       <= 1'b0;
      r_hdr_valid  <= 1'b0;
      r_pld_valid  <= 1'b0;
      r_pld_last   <= 1'b0;
      r_pld_strb   <= '0;
      r_pld_data   <= '0;
      r_trunc      <= 1'b0;
      r_data_id    <= '0;
      r_word_count <= '0;
      r_ecc        <= '0;
      r_rem        <= '0;
    end else begin
      r_wait      <= (w_next == SYNC) && (r_state != DONE);
      r_done      <= (r_state == DONE) && enable_i;
      r_hdr_valid <= w_hdr_beat && w_hdr_done;
      r_pld_valid <= w_pld_beat;
      r_pld_last  <= w_pld_beat && w_last;
      r_pld_strb  <= w_pld_beat ? w_strb : '0;
      r_pld_data  <= w_pld_beat ? word_i : '0;
      r_trunc     <= r_trunc | w_trunc;
      if (!enable_i) begin
        r_data_id    <= '0;
        r_word_count <= '0;
        r_ecc        <= '0;
        r_rem        <= '0;
      end else if (w_hdr_beat && w_hdr_done) begin
        r_data_id    <= w_hdr.data_id;
        r_word_count <= w_hdr.word_count;
        r_ecc        <= w_hdr.ecc;
        r_rem        <= w_short ? 17'd0 : {1'b0, w_hdr.word_count} + 17'(CRC_BYTES);
      end else if (w_pld_beat) begin
        r_rem <= w_last ? 17'd0 : r_rem - 17'(DATA_LANES);
      end
    end
  end

  assign wait_for_sync_o = r_wait;
  assign pkt_done_o      = r_done;
  assign hdr_valid_o     = r_hdr_valid;
  assign data_id_o       = r_data_id;
  assign word_count_o    = r_word_count;
  assign ecc_o           = r_ecc;
  assign pld_data_o      = r_pld_data;
  assign pld_valid_o     = r_pld_valid;
  assign pld_strb_o      = r_pld_strb;
  assign pld_last_o      = r_pld_last;
  assign trunc_err_o     = r_trunc;

endmodule

// File: tb/tb_csi2_pkt_ctrl.sv
// tb/tb_csi2_pkt_ctrl.sv - scoreboard bench for csi2_pkt_ctrl with 4-lane and 2-lane instances
module tb_csi2_pkt_ctrl;

  typedef struct {
    int kind;  // 0 header, 1 payload beat, 2 done pulse
    int a;
    int b;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic mon_on = 1'b0;
  exp_t q4[$];
  exp_t q2[$];
  int   sq[$];

  logic        en4 = 1'b1, v4 = 1'b0;
  logic [31:0] w4 = '0;
  logic        d4_ws, d4_done, d4_hv, d4_pv, d4_last, d4_trunc;
  logic [7:0]  d4_did, d4_ecc;
  logic [15:0] d4_wc;
  logic [31:0] d4_pdata;
  logic [3:0]  d4_strb;

  logic        en2 = 1'b1, v2 = 1'b0;
  logic [15:0] w2 = '0;
  logic        d2_ws, d2_done, d2_hv, d2_pv, d2_last, d2_trunc;
  logic [7:0]  d2_did, d2_ecc;
  logic [15:0] d2_wc;
  logic [15:0] d2_pdata;
  logic [1:0]  d2_strb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csi2_pkt_ctrl #(.DATA_LANES(4)) dut4 (
    .byte_clk_i(clk), .rst_n_i(rst_n), .enable_i(en4), .word_i(w4), .valid_i(v4),
    .wait_for_sync_o(d4_ws), .pkt_done_o(d4_done), .hdr_valid_o(d4_hv), .data_id_o(d4_did),
    .word_count_o(d4_wc), .ecc_o(d4_ecc), .pld_data_o(d4_pdata), .pld_valid_o(d4_pv),
    .pld_strb_o(d4_strb), .pld_last_o(d4_last), .trunc_err_o(d4_trunc)
  );

  csi2_pkt_ctrl #(.DATA_LANES(2)) dut2 (
    .byte_clk_i(clk), .rst_n_i(rst_n), .enable_i(en2), .word_i(w2), .valid_i(v2),
    .wait_for_sync_o(d2_ws), .pkt_done_o(d2_done), .hdr_valid_o(d2_hv), .data_id_o(d2_did),
    .word_count_o(d2_wc), .ecc_o(d2_ecc), .pld_data_o(d2_pdata), .pld_valid_o(d2_pv),
    .pld_strb_o(d2_strb), .pld_last_o(d2_last), .trunc_err_o(d2_trunc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, got, req);
    end
  endtask

  task automatic push(input int which, input int kind, input int a, input int b, input int c);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b; e.cyc = c;
    if (which == 4) q4.push_back(e);
    else            q2.push_back(e);
  endtask

  task automatic pop_cmp(input int which, input int kind, input int a, input int b, input string nm);
    exp_t e;
    checks++;
    if ((which == 4 && q4.size() == 0) || (which == 2 && q2.size() == 0)) begin
      failures++;
      $display("FAIL %s unexpected at cycle %0d: got a=%0h b=%0h, required no event", nm, cyc, a, b);
      return;
    end
    if (which == 4) e = q4.pop_front();
    else            e = q2.pop_front();
    if (e.kind != kind || e.a != a || e.b != b || e.cyc != cyc) begin
      failures++;
      $display("FAIL %s: got kind=%0d a=%0h b=%0h cycle=%0d, required kind=%0d a=%0h b=%0h cycle=%0d",
               nm, kind, a, b, cyc, e.kind, e.a, e.b, e.cyc);
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (d4_hv)   pop_cmp(4, 0, int'({d4_ecc, d4_did}), int'(d4_wc), "hdr4");
        if (d4_pv)   pop_cmp(4, 1, int'(d4_strb) | (int'(d4_last) << 8), int'(d4_pdata), "pld4");
        if (d4_done) pop_cmp(4, 2, 0, 0, "done4");
        if (d2_hv)   pop_cmp(2, 0, int'({d2_ecc, d2_did}), int'(d2_wc), "hdr2");
        if (d2_pv)   pop_cmp(2, 1, int'(d2_strb) | (int'(d2_last) << 8), int'(d2_pdata), "pld2");
        if (d2_done) pop_cmp(2, 2, 0, 0, "done2");
        if (d4_hv || d4_pv)   chk("hdr_pld_excl4", int'(d4_hv & d4_pv), 0);
        if (d4_ws || d4_done) chk("done_ws_excl4", int'(d4_ws & d4_done), 0);
        if (d2_hv || d2_pv)   chk("hdr_pld_excl2", int'(d2_hv & d2_pv), 0);
        if (d2_ws || d2_done) chk("done_ws_excl2", int'(d2_ws & d2_done), 0);
      end
    end
  endtask

  function automatic logic ws(input int which);
    return (which == 4) ? d4_ws : d2_ws;
  endfunction

  task automatic drive(input int which, input logic v, input logic [31:0] w);
    if (which == 4) begin v4 = v; w4 = w; end
    else            begin v2 = v; w2 = w[15:0]; end
  endtask

  task automatic wait_ws(input int which);
    int k = 0;
    while (!ws(which) && k < 40) begin step(); k++; end
    checks++;
    if (!ws(which)) begin
      failures++;
      $display("FAIL arm%0d: wait_for_sync_o got 0 after %0d cycles, required 1", which, k);
    end
  endtask

  // mode 0: complete packet, 1: valid_i dropped after sq.size() beats, 2: enable_i dropped instead
  task automatic send(input int which, input logic [7:0] did, input logic [15:0] wc,
                      input logic [7:0] ecc, input int mode);
    int h, n, t, dcyc;
    logic [31:0] hw, pw, mask;
    n    = sq.size();
    mask = (which == 4) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    wait_ws(which);
    hw = {ecc, wc, did};
    if (which == 4) begin
      drive(which, 1'b1, hw);
      h = cyc;
    end else begin
      drive(which, 1'b1, hw & mask);
      step();
      drive(which, 1'b1, hw >> 16);
      h = cyc;
    end
    push(which, 0, int'({ecc, did}), int'(wc), h + 1);
    for (int j = 1; j <= n; j++) begin
      step();
      pw = (32'h1111_1111 * j) & mask;
      drive(which, 1'b1, pw);
      push(which, 1, sq[j-1] | ((mode == 0 && j == n) ? 256 : 0), int'(pw), h + j + 1);
    end
    step();
    t = cyc;
    drive(which, 1'b0, 32'h0);
    if (mode == 2) begin
      en2 = 1'b0;
      step();
      chk("abort_wait2", int'(d2_ws), 0);
      chk("abort_pld2", int'(d2_pv), 0);
      en2 = 1'b1;
      step();
      chk("abort_rearm2", int'(d2_ws), 1);
    end else begin
      dcyc = (mode == 1) ? t + 2 : t + 1;
      push(which, 2, 0, 0, dcyc);
      while (cyc < dcyc + 1) step();
      chk("rearm_after_done", int'(ws(which)), 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    chk("reset_outputs", int'(|{d4_ws, d4_done, d4_hv, d4_did, d4_wc, d4_ecc, d4_pdata, d4_pv,
                               d4_strb, d4_last, d4_trunc, d2_ws, d2_done, d2_hv, d2_did, d2_wc,
                               d2_ecc, d2_pdata, d2_pv, d2_strb, d2_last, d2_trunc}), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arm_after_reset4", int'(d4_ws), 1);
    chk("arm_after_reset2", int'(d2_ws), 1);
    mon_on = 1'b1;
    fork
      monitor_loop();
    join_none

    sq = {};                          send(4, 8'h01, 16'h1234, 8'h3C, 0);
    sq = '{15, 15, 15};               send(4, 8'h2A, 16'd10,   8'h11, 0);
    sq = '{15, 7};                    send(4, 8'h2A, 16'd5,    8'h22, 0);
    sq = '{3};                        send(4, 8'h2A, 16'd0,    8'h33, 0);
    sq = {};                          send(4, 8'hCF, 16'hBEEF, 8'h44, 0);
    sq = '{15};                       send(4, 8'h10, 16'd2,    8'h55, 0);
    chk("trunc_before4", int'(d4_trunc), 0);
    sq = '{15, 15, 15, 15, 15};       send(4, 8'h2A, 16'd64,   8'h66, 1);
    chk("trunc_after4", int'(d4_trunc), 1);

    sq = '{3, 3, 1};                  send(2, 8'h2A, 16'd3,    8'h77, 0);
    sq = '{3, 3};                     send(2, 8'h2A, 16'd20,   8'h88, 2);
    sq = {};                          send(2, 8'h41, 16'h0007, 8'h99, 0);

    repeat (5) step();
    chk("queue_empty4", q4.size(), 0);
    chk("queue_empty2", q2.size(), 0);
    chk("trunc_sticky4", int'(d4_trunc), 1);
    chk("trunc_clear2", int'(d2_trunc), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
